// File: rtl/conv_transpose2d_scatter_acc_pkg.sv
// ============================================================================
// conv_op_pkg
// Shared state encoding, output-size derivation and round/saturate helpers.
// Revision: 1.0
// ============================================================================
`default_nettype none

package conv_op_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    ACCEPT  = 3'd2,
    SCATTER = 3'd3,
    DRAIN   = 3'd4
  } conv_state_e;

  function automatic int tconv_out_dim(input int in_dim, input int k, input int stride,
                                       input int pad);
    return (in_dim - 1) * stride - 2 * pad + k;
  endfunction

  function automatic int fwd_conv_out_dim(input int in_dim, input int k, input int stride,
                                          input int pad);
    return (in_dim + 2 * pad - k) / stride + 1;
  endfunction

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Round half-up at frac_w, then clamp to a signed data_w range (frac_w >= 1).
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] v,
                                                  input int frac_w, input int data_w);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (v + (64'sd1 <<< (frac_w - 1))) >>> frac_w;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (r > hi) return hi;
    if (r < lo) return lo;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv_transpose2d_scatter_acc_if.sv
// ============================================================================
// conv_transpose2d_scatter_acc_if
// Weight-load, control, input-stream and output-stream signals of the engine.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface conv_transpose2d_scatter_acc_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) ();
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;

  modport slave (
    input  w_we, w_addr, w_data, start, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );

  modport master (
    output w_we, w_addr, w_data, start, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );
endinterface

`default_nettype wire

// File: rtl/conv_transpose2d_scatter_acc_rq_sat.sv
// ============================================================================
// conv_rq_sat
// Combinational bias-add, round half-up and saturate from ACC_W to DATA_W.
// Revision: 1.0
// ============================================================================
`default_nettype none

module conv_rq_sat
  import conv_op_pkg::*;
#(
  parameter int ACC_W  = 40,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [DATA_W-1:0] bias,
  output logic signed [DATA_W-1:0] y
);
  logic signed [63:0] w_sum;
  logic signed [63:0] w_res;

  always_comb begin
    w_sum = 64'(acc) + (64'(bias) <<< FRAC_W);
    w_res = round_sat(w_sum, FRAC_W, DATA_W);
    y     = DATA_W'(w_res);
  end
endmodule

`default_nettype wire

// File: rtl/conv_transpose2d_scatter_acc.sv
// ============================================================================
// conv_transpose2d_scatter_acc
// Single-channel transposed 2D convolution: scatter-accumulate into a frame
// buffer, then stream the cropped result with bias, rounding and saturation.
// Revision: 1.0
// ============================================================================
`default_nettype none

module conv_transpose2d_scatter_acc
  import conv_op_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 8,
  parameter int ACC_W    = 40,
  parameter int IN_H     = 4,
  parameter int IN_W     = 5,
  parameter int K_H      = 3,
  parameter int K_W      = 2,
  parameter int STRIDE_H = 2,
  parameter int STRIDE_W = 1,
  parameter int PAD_H    = 1,
  parameter int PAD_W    = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  conv_transpose2d_scatter_acc_if.slave  bus
);
  localparam int OUT_H = tconv_out_dim(IN_H, K_H, STRIDE_H, PAD_H);
  localparam int OUT_W = tconv_out_dim(IN_W, K_W, STRIDE_W, PAD_W);
  localparam int NOUT  = OUT_H * OUT_W;
  localparam int NTAP  = K_H * K_W;
  localparam int IDX_W = clog2_min1(NOUT);
  localparam int TAP_W = clog2_min1(NTAP + 1);
  localparam int IH_W  = clog2_min1(IN_H);
  localparam int IW_W  = clog2_min1(IN_W);
  localparam int KH_W  = clog2_min1(K_H);
  localparam int KW_W  = clog2_min1(K_W);

  localparam logic [2:0] ST_IDLE    = IDLE;
  localparam logic [2:0] ST_CLEAR   = CLEAR;
  localparam logic [2:0] ST_ACCEPT  = ACCEPT;
  localparam logic [2:0] ST_SCATTER = SCATTER;
  localparam logic [2:0] ST_DRAIN   = DRAIN;

  logic [2:0]               r_state;
  logic signed [DATA_W-1:0] r_wt [NTAP];
  logic signed [DATA_W-1:0] r_bias;
  logic signed [DATA_W-1:0] r_pix;
  logic signed [ACC_W-1:0]  r_acc [NOUT];
  logic [IDX_W-1:0]         r_clr_idx;
  logic [IDX_W-1:0]         r_rd_idx;
  logic [IH_W-1:0]          r_ih;
  logic [IW_W-1:0]          r_iw;
  logic [KH_W-1:0]          r_kh;
  logic [KW_W-1:0]          r_kw;
  logic                     r_in_ready;
  logic                     r_out_valid;
  logic                     r_out_last;
  logic [DATA_W-1:0]        r_out_data;

  int                         w_oh;
  int                         w_ow;
  logic                       w_hit;
  logic [IDX_W-1:0]           w_wr_idx;
  logic [TAP_W-1:0]           w_tap;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_acc_sum;
  logic                       w_last_tap;
  logic                       w_last_pix;
  logic signed [DATA_W-1:0]   w_rq_data;

  always_comb begin
    w_oh       = int'(r_ih) * STRIDE_H + int'(r_kh) - PAD_H;
    w_ow       = int'(r_iw) * STRIDE_W + int'(r_kw) - PAD_W;
    w_hit      = (w_oh >= 0) && (w_oh < OUT_H) && (w_ow >= 0) && (w_ow < OUT_W);
    w_wr_idx   = w_hit ? IDX_W'(w_oh * OUT_W + w_ow) : '0;
    w_tap      = TAP_W'(int'(r_kh) * K_W + int'(r_kw));
    w_prod     = r_pix * r_wt[w_tap];
    w_acc_sum  = r_acc[w_wr_idx] + {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
    w_last_tap = (r_kh == KH_W'(K_H - 1)) && (r_kw == KW_W'(K_W - 1));
    w_last_pix = (r_ih == IH_W'(IN_H - 1)) && (r_iw == IW_W'(IN_W - 1));
  end

  conv_rq_sat #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_rq_sat (
    .acc  (r_acc[r_rd_idx]),
    .bias (r_bias),
    .y    (w_rq_data)
  );

  // Frame buffer has no reset: CLEAR rewrites every entry before each frame.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_acc[r_clr_idx] <= '0;
    end else if (r_state == ST_SCATTER && w_hit) begin
      r_acc[w_wr_idx] <= w_acc_sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < NTAP; t++) r_wt[t] <= '0;
      r_bias <= '0;
    end else if (r_state == ST_IDLE && bus.w_we) begin
      if (bus.w_addr == TAP_W'(NTAP)) begin
        r_bias <= bus.w_data;
      end else if (bus.w_addr < TAP_W'(NTAP)) begin
        r_wt[bus.w_addr] <= bus.w_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_pix       <= '0;
      r_clr_idx   <= '0;
      r_rd_idx    <= '0;
      r_ih        <= '0;
      r_iw        <= '0;
      r_kh        <= '0;
      r_kw        <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= '0;
            r_ih      <= '0;
            r_iw      <= '0;
          end
        end
        ST_CLEAR: begin
          if (r_clr_idx == IDX_W'(NOUT - 1)) begin
            r_state    <= ST_ACCEPT;
            r_in_ready <= 1'b1;
          end else begin
            r_clr_idx <= r_clr_idx + IDX_W'(1);
          end
        end
        ST_ACCEPT: begin
          if (bus.in_valid && r_in_ready) begin
            r_pix      <= bus.in_data;
            r_kh       <= '0;
            r_kw       <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_SCATTER;
          end
        end
        ST_SCATTER: begin
          if (w_last_tap) begin
            r_kh <= '0;
            r_kw <= '0;
            if (w_last_pix) begin
              r_state  <= ST_DRAIN;
              r_ih     <= '0;
              r_iw     <= '0;
              r_rd_idx <= '0;
            end else begin
              r_state    <= ST_ACCEPT;
              r_in_ready <= 1'b1;
              if (r_iw == IW_W'(IN_W - 1)) begin
                r_iw <= '0;
                r_ih <= r_ih + IH_W'(1);
              end else begin
                r_iw <= r_iw + IW_W'(1);
              end
            end
          end else if (r_kw == KW_W'(K_W - 1)) begin
            r_kw <= '0;
            r_kh <= r_kh + KH_W'(1);
          end else begin
            r_kw <= r_kw + KW_W'(1);
          end
        end
        ST_DRAIN: begin
          // Output register refills whenever it is empty or being consumed.
          if (!r_out_valid || bus.out_ready) begin
            if (r_out_valid && r_out_last) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_state     <= ST_IDLE;
            end else begin
              r_out_valid <= 1'b1;
              r_out_data  <= w_rq_data;
              r_out_last  <= (r_rd_idx == IDX_W'(NOUT - 1));
              if (r_rd_idx != IDX_W'(NOUT - 1)) r_rd_idx <= r_rd_idx + IDX_W'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign bus.busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_conv_transpose2d_scatter_acc.sv
// ============================================================================
// tb_conv_transpose2d_scatter_acc
// Directed and randomized frames checked against a direct transposed-conv model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_conv_transpose2d_scatter_acc;
  localparam int DATA_W = 16, FRAC_W = 8, ACC_W = 40;
  localparam int IN_H = 4, IN_W = 5, K_H = 3, K_W = 2;
  localparam int STRIDE_H = 2, STRIDE_W = 1, PAD_H = 1, PAD_W = 0;
  localparam int OUT_H   = (IN_H - 1) * STRIDE_H - 2 * PAD_H + K_H;
  localparam int OUT_W   = (IN_W - 1) * STRIDE_W - 2 * PAD_W + K_W;
  localparam int NIN     = IN_H * IN_W;
  localparam int NOUT    = OUT_H * OUT_W;
  localparam int NTAP    = K_H * K_W;
  localparam int ADDR_W  = $clog2(NTAP + 1);
  localparam int LATENCY = NOUT + NIN * (1 + NTAP) + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  conv_transpose2d_scatter_acc_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  conv_transpose2d_scatter_acc #(
    .DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W), .IN_H(IN_H), .IN_W(IN_W),
    .K_H(K_H), .K_W(K_W), .STRIDE_H(STRIDE_H), .STRIDE_W(STRIDE_W),
    .PAD_H(PAD_H), .PAD_W(PAD_W)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic signed [15:0] tw [NTAP];
  logic signed [15:0] tbias;
  logic signed [15:0] tin [NIN];
  logic [15:0] exp_d [NOUT];
  logic [15:0] got_d [$];
  logic        got_l [$];
  logic [15:0] ref_d [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Direct transposed convolution over the whole frame, then bias/round/clamp.
  function automatic void model();
    longint acc [NOUT];
    longint v;
    int oh, ow;
    for (int i = 0; i < NOUT; i++) acc[i] = 0;
    for (int ih = 0; ih < IN_H; ih++)
      for (int iw = 0; iw < IN_W; iw++)
        for (int kh = 0; kh < K_H; kh++)
          for (int kw = 0; kw < K_W; kw++) begin
            oh = ih * STRIDE_H + kh - PAD_H;
            ow = iw * STRIDE_W + kw - PAD_W;
            if (oh >= 0 && oh < OUT_H && ow >= 0 && ow < OUT_W)
              acc[oh*OUT_W+ow] += longint'(tin[ih*IN_W+iw]) * longint'(tw[kh*K_W+kw]);
          end
    for (int i = 0; i < NOUT; i++) begin
      v = acc[i] + longint'(tbias) * (64'sd1 <<< FRAC_W);
      v = (v + (64'sd1 <<< (FRAC_W - 1))) >>> FRAC_W;
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
      exp_d[i] = v[15:0];
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    bus.w_we   = 1'b1;
    bus.w_addr = ADDR_W'(a);
    bus.w_data = d;
    tick();
    bus.w_we   = 1'b0;
  endtask

  task automatic load_all();
    for (int t = 0; t < NTAP; t++) wr(t, tw[t]);
    wr(NTAP, tbias);
  endtask

  task automatic set_impulse();
    for (int t = 0; t < NTAP; t++) tw[t] = 16'(((t / K_W) * 2 + (t % K_W) + 1) * 256);
    tbias = 16'sd0;
    for (int p = 0; p < NIN; p++) tin[p] = 16'sd0;
    tin[0] = 16'sd256;
  endtask

  task automatic randomize_frame();
    for (int t = 0; t < NTAP; t++) tw[t] = 16'(int'($urandom_range(2047, 0)) - 1024);
    for (int p = 0; p < NIN; p++) tin[p] = 16'(int'($urandom_range(2047, 0)) - 1024);
    tbias = 16'($urandom);
  endtask

  task automatic send(input int p, input int gap_max);
    int k;
    logic rdy;
    if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) tick();
    bus.in_valid = 1'b1;
    bus.in_data  = tin[p];
    k = 0;
    do begin
      rdy = bus.in_ready;
      tick();
      k++;
    end while (!rdy && k < 1000);
    bus.in_valid = 1'b0;
    bus.in_data  = 16'($urandom);
    if (!rdy) begin
      check("in_ready_timeout", 32'd0, 32'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "input handshake never completed");
    end
  endtask

  task automatic run_frame(input int gap_max, input bit stall, input bit ctl, input bit lat);
    int k;
    logic v, l, rdy, prev_stall, first, pl;
    logic [15:0] d, pd;
    int unsigned t0;
    got_d.delete();
    got_l.delete();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    t0 = cyc;
    for (int p = 0; p < NIN; p++) begin
      send(p, gap_max);
      if (ctl && p == 0) begin
        bus.w_we   = 1'b1;
        bus.w_addr = ADDR_W'($urandom_range(NTAP, 0));
        bus.w_data = 16'($urandom);
        bus.start  = 1'b1;
        tick();
        bus.w_we   = 1'b0;
        bus.start  = 1'b0;
      end
    end
    k = 0; prev_stall = 1'b0; first = 1'b1; pd = '0; pl = 1'b0;
    while (got_d.size() < NOUT && k < 4000) begin
      rdy = stall ? (k % 3 == 0) : 1'b1;
      bus.out_ready = rdy;
      v = bus.out_valid;
      d = bus.out_data;
      l = bus.out_last;
      bus.start = ctl && v && (got_d.size() == 5);
      if (prev_stall) begin
        check("stall_valid", 32'(v), 32'd1);
        check("stall_data", 32'(d), 32'(pd));
        check("stall_last", 32'(l), 32'(pl));
      end
      if (lat && first && v) begin
        check("latency", cyc - t0, LATENCY);
        first = 1'b0;
      end
      tick();
      k++;
      if (v && rdy) begin
        got_d.push_back(d);
        got_l.push_back(l);
      end
      prev_stall = v && !rdy;
      pd = d;
      pl = l;
    end
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    check("xfer_count", 32'(got_d.size()), NOUT);
    check("busy_after_last", 32'(bus.busy), 32'd0);
    check("valid_after_last", 32'(bus.out_valid), 32'd0);
    tick();
    tick();
    check("busy_stays_idle", 32'(bus.busy), 32'd0);
  endtask

  task automatic verify_frame(input string tag);
    model();
    for (int i = 0; i < got_d.size(); i++) begin
      check($sformatf("%s_px%0d", tag, i), 32'(got_d[i]), 32'(exp_d[i]));
      check($sformatf("%s_last%0d", tag, i), 32'(got_l[i]), 32'(i == NOUT - 1));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_last"}, 32'(bus.out_last), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
  endtask

  initial begin
    bus.w_we = 1'b0; bus.w_addr = '0; bus.w_data = '0; bus.start = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check_reset_outputs("reset");

    // Weights cleared by reset: only the bias reaches the output.
    for (int t = 0; t < NTAP; t++) tw[t] = 16'sd0;
    for (int p = 0; p < NIN; p++) tin[p] = 16'($urandom);
    tbias = 16'($urandom);
    wr(NTAP, tbias);
    run_frame(0, 1'b0, 1'b0, 1'b0);
    verify_frame("bias_only");

    set_impulse();
    load_all();
    run_frame(0, 1'b0, 1'b0, 1'b1);
    verify_frame("impulse");
    check("imp_00", 32'(got_d[0]), 32'd768);
    check("imp_01", 32'(got_d[1]), 32'd1024);
    check("imp_10", 32'(got_d[OUT_W]), 32'd1280);
    check("imp_11", 32'(got_d[OUT_W+1]), 32'd1536);

    for (int t = 0; t < NTAP; t++) tw[t] = 16'sd256;
    for (int p = 0; p < NIN; p++) tin[p] = 16'sd256;
    tbias = 16'sd128;
    load_all();
    run_frame(0, 1'b0, 1'b0, 1'b0);
    verify_frame("ones");
    check("ones_00", 32'(got_d[0]), 32'd384);
    // out(1,2): rows (ih0,kh2),(ih1,kh0) x cols (iw1,kw1),(iw2,kw0) = 4 taps.
    check("ones_12", 32'(got_d[OUT_W+2]), 32'd1152);

    for (int t = 0; t < NTAP; t++) tw[t] = 16'sh7F00;
    for (int p = 0; p < NIN; p++) tin[p] = 16'sh7F00;
    tbias = 16'sd0;
    load_all();
    run_frame(0, 1'b0, 1'b0, 1'b0);
    verify_frame("sat_pos");
    check("sat_pos_00", 32'(got_d[0]), 32'h7FFF);
    for (int p = 0; p < NIN; p++) tin[p] = 16'sh8100;
    run_frame(0, 1'b0, 1'b0, 1'b0);
    verify_frame("sat_neg");
    check("sat_neg_00", 32'(got_d[0]), 32'h8000);

    randomize_frame();
    load_all();
    run_frame(0, 1'b0, 1'b0, 1'b1);
    verify_frame("rand");
    ref_d = got_d;
    run_frame(3, 1'b1, 1'b0, 1'b0);
    verify_frame("rand_stall");
    for (int i = 0; i < got_d.size(); i++)
      check($sformatf("stall_seq%0d", i), 32'(got_d[i]), 32'(ref_d[i]));

    set_impulse();
    load_all();
    run_frame(1, 1'b0, 1'b1, 1'b0);
    verify_frame("ctl");

    randomize_frame();
    load_all();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int p = 0; p < 3; p++) send(p, 0);
    rst = 1'b1;
    #2;
    check("async_rst_busy", 32'(bus.busy), 32'd0);
    check("async_rst_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_rst");

    set_impulse();
    for (int t = 0; t < NTAP; t++) tw[t] = 16'sd0;
    run_frame(0, 1'b0, 1'b0, 1'b0);
    verify_frame("post_rst_zero");
    set_impulse();
    load_all();
    run_frame(0, 1'b0, 1'b0, 1'b1);
    verify_frame("post_rst_imp");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
